seq_scan_arbiter: RTL and testbench
===================================

// Module: seq_scan_arbiter
// PURPOSE
//  Shares one "1001" Moore sequence-detector instance between N_REQ requesters. Each requester
//  supplies a WORD_W-bit word. A round-robin arbiter grants one requester at a time. The granted
//  word is serialised MSB-first into the detector, and the detector's F pulses are counted. The
//  block then reports the match count and the requester id.
//  It sits between the client logic and the detector: it drives the detector's I and reset inputs
//  and observes its F output.
// PARAMETERS
//  N_REQ   4  number of requesters (>=2)
//  WORD_W  8  bits per word shifted into the detector (>=4)
//  CNT_W   4  width of match_cnt; the count saturates at 2**CNT_W-1
// PORTS
//  clock     in   1                rising-edge clock
//  reset     in   1                asynchronous, active-low reset (0 = reset)
//  req       in   N_REQ            req[i]=1: requester i has a word pending; held until gnt[i]
//  word_in   in   N_REQ*WORD_W     word i occupies bits [i*WORD_W +: WORD_W]
//  gnt       out  N_REQ            one-hot, single-cycle grant; word i was captured on the edge it rose
//  busy      out  1                1 whenever the FSM is not in IDLE
//  done      out  1                single-cycle pulse: result valid
//  done_id   out  $clog2(N_REQ)    requester index of the result; valid while done=1
//  match_cnt out  CNT_W            detections in the word; valid while done=1
//  det_rst   out  1                active-high synchronous reset to the detector
//  det_I     out  1                serial bit to the detector
//  det_F     in   1                detector Moore output (reflects state after the previous det_I bit)
// BEHAVIOUR
//  Reset (reset=0, asynchronous): state=IDLE; gnt=0, busy=0, done=0, done_id=0, match_cnt=0,
//    det_I=0, det_rst=1; the round-robin pointer is set to N_REQ-1, so req[0] has top priority.
//    Reset asserted mid-transaction aborts the transaction immediately, with no done pulse.
//  All outputs are registered. States and transitions:
//  IDLE:  det_rst=1. If any req bit is set, pick the first set bit searching from ptr+1 (mod N_REQ).
//         At the clock edge: latch that word, set ptr to the chosen index, pulse that gnt bit,
//         and go to CLEAR. With no request, remain in IDLE.
//  CLEAR: gnt high for this one cycle; det_rst=1, det_I=0; cnt=0; bit index k=0; go to SHIFT.
//  SHIFT: det_rst=0; det_I = word[WORD_W-1-k]. If k>=1 and det_F=1, cnt+=1 (saturating).
//         k increments each cycle; after k=WORD_W-1, go to DRAIN.
//  DRAIN: det_I=0; if det_F=1, cnt+=1 (saturating); this covers the last bit; go to DONE.
//  DONE:  done=1, done_id=ptr, match_cnt=cnt; det_rst=1; go to IDLE.
//  Latency:
//    - Requests are sampled in IDLE cycle T.
//    - gnt is high in cycle T+1 and done is high in cycle T+WORD_W+3.
//    - The next grant can be sampled in cycle T+WORD_W+4.
//  Arbitration and requester rules:
//    - Requester i must deassert req[i] at the edge that ends its gnt cycle, or it is served again.
//    - A req dropped before its grant is ignored.
//    - req changes during a transaction have no effect until IDLE.
//    - word_in is sampled only at the IDLE->CLEAR edge.
//  Detections are overlapping, e.g. 1001001 gives 2. match_cnt and done_id hold their last values
//    after done; they are valid only while done=1.
// TESTING
//  1 Reset released, req=0001, word0=8'b1001_0000 -> gnt=0001 at T+1, done at T+11, done_id=0, match_cnt=1
//  2 word0=8'b1001_0010 (overlap) -> match_cnt=2; word0=8'hFF -> 0; word0=8'h00 -> 0
//  3 req=1011 held (each drops on its gnt), then req0+req3 re-raised after third done
//      -> grant order 0,1,3 at 12-cycle spacing, then 0 before 3
//  4 Reset pulled low during SHIFT (k=3)
//      -> same cycle: busy=0, det_rst=1, gnt=0, no done
//      -> after release, pending req2 and req0: req0 granted first
//  5 CNT_W=1, word0=8'b1001_0010 -> match_cnt=1 (saturated)
//  6 det_F forced to 1 during CLEAR and SHIFT k=0 -> not counted; forced in DRAIN -> counted

Source files
------------

// File: rtl/seq_scan_arbiter.sv
// -----------------------------------------------------------------------------
// seq_scan_arbiter
//
// Shares one external "1001" Moore sequence detector between N_REQ requesters.
// A round-robin arbiter picks one pending requester, captures its word and
// serialises it MSB-first into the detector. The detector's F pulses are
// counted (saturating) and reported with the requester id as a one-cycle
// done pulse.
//
// Ports
//   clock      rising-edge clock
//   reset      asynchronous, active-low reset
//   req        per-requester pending flag, held until the matching gnt bit
//   word_in    packed words, requester i at [i*WORD_W +: WORD_W]
//   gnt        one-hot single-cycle grant (word captured on its rising edge)
//   busy       high whenever the controller is not idle
//   done       one-cycle result strobe
//   done_id    requester index of the result (valid with done)
//   match_cnt  saturating detection count (valid with done)
//   det_rst    active-high synchronous reset to the detector
//   det_I      serial bit to the detector
//   det_F      detector Moore output (state after the previous det_I bit)
//
// Every output is a register loaded with the value belonging to the state
// being entered, so the controller's next-state logic also computes the next
// output values.
// -----------------------------------------------------------------------------
module seq_scan_arbiter #(
  parameter int N_REQ  = 4,
  parameter int WORD_W = 8,
  parameter int CNT_W  = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [N_REQ-1:0]           req,
  input  logic [N_REQ*WORD_W-1:0]    word_in,
  output logic [N_REQ-1:0]           gnt,
  output logic                       busy,
  output logic                       done,
  output logic [$clog2(N_REQ)-1:0]   done_id,
  output logic [CNT_W-1:0]           match_cnt,
  output logic                       det_rst,
  output logic                       det_I,
  input  logic                       det_F
);

  localparam int ID_W = $clog2(N_REQ);
  localparam int K_W  = $clog2(WORD_W);
  localparam logic [K_W-1:0] K_LAST = K_W'(WORD_W - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_SHIFT,
    S_DRAIN,
    S_DONE
  } state_t;

  // Count increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Requester index 'off' positions after 'base', wrapping modulo N_REQ.
  // off is always in 1..N_REQ, so a single subtraction is enough.
  function automatic logic [ID_W-1:0] rr_idx(input logic [ID_W-1:0] base,
                                             input int              off);
    int s;
    s = int'(base) + off;
    if (s >= N_REQ) s = s - N_REQ;
    return ID_W'(s);
  endfunction

  state_t               state_q, state_d;
  logic [ID_W-1:0]      ptr_q, ptr_d;
  logic [K_W-1:0]       k_q, k_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [WORD_W-1:0]    sh_q, sh_d;

  logic [N_REQ-1:0]     gnt_d;
  logic                 busy_d;
  logic                 done_d;
  logic [ID_W-1:0]      done_id_d;
  logic [CNT_W-1:0]     match_cnt_d;
  logic                 det_rst_d;
  logic                 det_I_d;

  logic [WORD_W-1:0]    words [N_REQ];
  logic                 pick_vld;
  logic [ID_W-1:0]      pick_id;
  logic [ID_W-1:0]      cand;

  for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
    assign words[g] = word_in[g*WORD_W +: WORD_W];
  end

  // Round-robin search: first pending requester after the last one granted.
  always_comb begin
    pick_vld = 1'b0;
    pick_id  = '0;
    cand     = '0;
    for (int o = 1; o <= N_REQ; o++) begin
      cand = rr_idx(ptr_q, o);
      if (!pick_vld && req[cand]) begin
        pick_vld = 1'b1;
        pick_id  = cand;
      end
    end
  end

  // Next state and next (registered) outputs.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    k_d         = k_q;
    cnt_d       = cnt_q;
    sh_d        = sh_q;
    gnt_d       = '0;
    done_d      = 1'b0;
    done_id_d   = done_id;
    match_cnt_d = match_cnt;
    det_rst_d   = 1'b1;
    det_I_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (pick_vld) begin
          state_d        = S_CLEAR;
          ptr_d          = pick_id;
          gnt_d[pick_id] = 1'b1;
          sh_d           = words[pick_id];
        end
      end

      // Detector is held in reset this cycle; first bit goes out next.
      S_CLEAR: begin
        state_d   = S_SHIFT;
        cnt_d     = '0;
        k_d       = '0;
        det_rst_d = 1'b0;
        det_I_d   = sh_q[WORD_W-1];
        sh_d      = sh_q << 1;
      end

      // det_F lags det_I by one bit, so the k=0 cycle still shows the
      // cleared detector and is not counted.
      S_SHIFT: begin
        det_rst_d = 1'b0;
        if ((k_q != '0) && det_F) cnt_d = sat_inc(cnt_q);
        if (k_q == K_LAST) begin
          state_d = S_DRAIN;
        end else begin
          k_d     = k_q + 1'b1;
          det_I_d = sh_q[WORD_W-1];
          sh_d    = sh_q << 1;
        end
      end

      // det_F now reflects the last word bit.
      S_DRAIN: begin
        state_d     = S_DONE;
        match_cnt_d = det_F ? sat_inc(cnt_q) : cnt_q;
        cnt_d       = match_cnt_d;
        done_d      = 1'b1;
        done_id_d   = ptr_q;
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // Control and output registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      ptr_q     <= ID_W'(N_REQ - 1);
      k_q       <= '0;
      gnt       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      done_id   <= '0;
      match_cnt <= '0;
      det_rst   <= 1'b1;
      det_I     <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      k_q       <= k_d;
      gnt       <= gnt_d;
      busy      <= busy_d;
      done      <= done_d;
      done_id   <= done_id_d;
      match_cnt <= match_cnt_d;
      det_rst   <= det_rst_d;
      det_I     <= det_I_d;
    end
  end

  // Data registers: always loaded before use, so no reset.
  always_ff @(posedge clock) begin
    sh_q  <= sh_d;
    cnt_q <= cnt_d;
  end

endmodule

// File: tb/tb_seq_scan_arbiter.sv
// -----------------------------------------------------------------------------
// tb_seq_scan_arbiter
//
// Two instances share the request stimulus: dut uses the default CNT_W=4,
// dut2 uses CNT_W=1 to exercise count saturation. Each instance drives its own
// behavioural "1001" Moore detector; det_F of the first can be forced high.
// -----------------------------------------------------------------------------
module tb_seq_scan_arbiter;

  logic        clock   = 1'b0;
  logic        reset   = 1'b0;
  logic [3:0]  req     = '0;
  logic [31:0] word_in = '0;

  logic [3:0]  gnt, gnt2;
  logic        busy, busy2, done, done2;
  logic [1:0]  done_id, done_id2;
  logic [3:0]  match_cnt;
  logic [0:0]  match_cnt2;
  logic        det_rst, det_I, det_F;
  logic        det_rst2, det_I2, det_F2;

  logic        f_ovr = 1'b0;
  logic [2:0]  ds1 = 3'd0;
  logic [2:0]  ds2 = 3'd0;

  int cyc     = 0;
  int nchecks = 0;
  int nerrors = 0;

  seq_scan_arbiter #(.N_REQ(4), .WORD_W(8), .CNT_W(4)) dut (
    .clock(clock), .reset(reset), .req(req), .word_in(word_in),
    .gnt(gnt), .busy(busy), .done(done), .done_id(done_id),
    .match_cnt(match_cnt), .det_rst(det_rst), .det_I(det_I), .det_F(det_F)
  );

  seq_scan_arbiter #(.N_REQ(4), .WORD_W(8), .CNT_W(1)) dut2 (
    .clock(clock), .reset(reset), .req(req), .word_in(word_in),
    .gnt(gnt2), .busy(busy2), .done(done2), .done_id(done_id2),
    .match_cnt(match_cnt2), .det_rst(det_rst2), .det_I(det_I2), .det_F(det_F2)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // "1001" overlapping Moore detector: states 0..4 = "", "1", "10", "100", "1001".
  function automatic logic [2:0] dnext(input logic [2:0] s, input logic b);
    case (s)
      3'd0:    return b ? 3'd1 : 3'd0;
      3'd1:    return b ? 3'd1 : 3'd2;
      3'd2:    return b ? 3'd1 : 3'd3;
      3'd3:    return b ? 3'd4 : 3'd0;
      3'd4:    return b ? 3'd1 : 3'd2;
      default: return 3'd0;
    endcase
  endfunction

  always @(posedge clock) ds1 <= det_rst  ? 3'd0 : dnext(ds1, det_I);
  always @(posedge clock) ds2 <= det_rst2 ? 3'd0 : dnext(ds2, det_I2);
  assign det_F  = f_ovr | (ds1 == 3'd4);
  assign det_F2 = (ds2 == 3'd4);

  task automatic chk(input string nm, input int act, input int exp);
    nchecks++;
    if (act != exp) begin
      nerrors++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic wait_gnt(output bit got);
    got = 1'b0;
    for (int w = 0; w < 40 && !got; w++) begin
      @(negedge clock);
      if (gnt != 0) got = 1'b1;
    end
  endtask

  // Waits for a grant to requester id, drops its req, then follows the
  // transaction to done. fmode 1 forces det_F during CLEAR and k=0,
  // fmode 2 forces det_F during DRAIN.
  task automatic serve(input int id, input int ec1, input int ec2,
                       input int fmode, input string nm, output int tg);
    bit got;
    int r;
    wait_gnt(got);
    tg = cyc;
    chk({nm, " gnt seen"}, int'(got), 1);
    if (!got) return;
    chk({nm, " gnt"}, int'(gnt), 1 << id);
    chk({nm, " gnt2"}, int'(gnt2), 1 << id);
    req[id[1:0]] = 1'b0;
    if (fmode == 1) f_ovr = 1'b1;
    got = 1'b0;
    r = 0;
    while (r < 40 && !got) begin
      @(negedge clock);
      r++;
      if (fmode == 1 && r == 2)  f_ovr = 1'b0;
      if (fmode == 2 && r == 9)  f_ovr = 1'b1;
      if (fmode == 2 && r == 10) f_ovr = 1'b0;
      if (r == 1) begin
        chk({nm, " gnt single cycle"}, int'(gnt), 0);
        chk({nm, " busy in shift"}, int'(busy), 1);
        chk({nm, " det_rst in shift"}, int'(det_rst), 0);
      end
      if (done) begin
        got = 1'b1;
        chk({nm, " done latency"}, r, 10);
        chk({nm, " done_id"}, int'(done_id), id);
        chk({nm, " match_cnt"}, int'(match_cnt), ec1);
        chk({nm, " done2"}, int'(done2), 1);
        chk({nm, " done_id2"}, int'(done_id2), id);
        chk({nm, " match_cnt2"}, int'(match_cnt2), ec2);
        chk({nm, " det_rst in done"}, int'(det_rst), 1);
      end
    end
    f_ovr = 1'b0;
    chk({nm, " done seen"}, int'(got), 1);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b0;
    req   = '0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
  endtask

  typedef struct {
    logic [3:0] req;
    logic [7:0] w;
    int         id;
    int         c1;
    int         c2;
    int         fmode;
  } vec_t;

  vec_t vt [9];

  initial begin
    int t0, tg, tp, seen;
    bit got;

    vt[0] = '{4'b0001, 8'b1001_0000, 0, 1, 1, 0};
    vt[1] = '{4'b0001, 8'b1001_0010, 0, 2, 1, 0};
    vt[2] = '{4'b0001, 8'hFF,        0, 0, 0, 0};
    vt[3] = '{4'b0001, 8'h00,        0, 0, 0, 0};
    vt[4] = '{4'b0100, 8'b0000_1001, 2, 1, 1, 0};
    vt[5] = '{4'b0010, 8'b1001_0011, 1, 2, 1, 0};
    vt[6] = '{4'b0001, 8'h00,        0, 0, 0, 1};
    vt[7] = '{4'b0001, 8'h00,        0, 1, 0, 2};
    vt[8] = '{4'b1000, 8'b1001_1001, 3, 2, 1, 0};

    // Reset state
    repeat (3) @(negedge clock);
    chk("rst gnt", int'(gnt), 0);
    chk("rst busy", int'(busy), 0);
    chk("rst busy2", int'(busy2), 0);
    chk("rst done", int'(done), 0);
    chk("rst done_id", int'(done_id), 0);
    chk("rst match_cnt", int'(match_cnt), 0);
    chk("rst det_I", int'(det_I), 0);
    chk("rst det_rst", int'(det_rst), 1);
    reset = 1'b1;
    @(negedge clock);
    chk("idle busy", int'(busy), 0);

    // Single-requester vectors
    for (int i = 0; i < 9; i++) begin
      @(posedge clock);
      #1;
      word_in = 32'(vt[i].w) << (vt[i].id * 8);
      req     = vt[i].req;
      t0      = cyc;
      serve(vt[i].id, vt[i].c1, vt[i].c2, vt[i].fmode, $sformatf("vec%0d", i), tg);
      chk($sformatf("vec%0d grant latency", i), tg - t0, 1);
    end

    // Round robin: 0,1,3 at 12-cycle spacing, then 0 before 3
    do_reset();
    word_in = {8'hFF, 8'h00, 8'b1001_0010, 8'b1001_0000};
    @(posedge clock);
    #1;
    req = 4'b1011;
    t0  = cyc;
    serve(0, 1, 1, 0, "rr g0", tg);
    chk("rr g0 latency", tg - t0, 1);
    tp = tg;
    serve(1, 2, 1, 0, "rr g1", tg);
    chk("rr g1 spacing", tg - tp, 12);
    tp = tg;
    serve(3, 0, 0, 0, "rr g3", tg);
    chk("rr g3 spacing", tg - tp, 12);
    @(posedge clock);
    #1;
    req = 4'b1001;
    serve(0, 1, 1, 0, "rr again g0", tg);
    tp = tg;
    serve(3, 0, 0, 0, "rr again g3", tg);
    chk("rr again spacing", tg - tp, 12);

    // Reset in the middle of SHIFT
    do_reset();
    word_in = {8'h00, 8'b0000_1001, 8'h00, 8'b1001_0000};
    @(posedge clock);
    #1;
    req = 4'b0001;
    wait_gnt(got);
    chk("abort gnt seen", int'(got), 1);
    req = 4'b0101;
    repeat (4) @(negedge clock);
    chk("abort busy before", int'(busy), 1);
    chk("abort det_rst before", int'(det_rst), 0);
    reset = 1'b0;
    #1;
    chk("abort busy", int'(busy), 0);
    chk("abort det_rst", int'(det_rst), 1);
    chk("abort gnt", int'(gnt), 0);
    chk("abort done", int'(done), 0);
    chk("abort det_I", int'(det_I), 0);
    seen = 0;
    repeat (3) begin
      @(negedge clock);
      if (done || done2) seen++;
    end
    chk("abort no done", seen, 0);
    reset = 1'b1;
    serve(0, 1, 1, 0, "post-abort g0", tg);
    serve(2, 1, 1, 0, "post-abort g2", tg);

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

endmodule
